// File: rtl/rv32_pkg.sv
// Shared RV32 constants: ALU g_sel codes, MDU op encodings and sequencer FSM states.
package rv32_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;

  typedef logic [1:0] mdu_op_t;

  localparam mdu_op_t MDU_MUL   = 2'b00;
  localparam mdu_op_t MDU_MULHU = 2'b01;
  localparam mdu_op_t MDU_DIVU  = 2'b10;
  localparam mdu_op_t MDU_REMU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mdu_alu_sequencer_if.sv
// Request/response bus of the multiply/divide sequencer.
// Handshake: a beat transfers on a rising edge where valid & ready are both 1; valid, once
// raised, holds its payload until that edge, and ready may never depend on a future valid.
interface mdu_alu_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/mdu_alu_sequencer.sv
// Multi-cycle MUL/MULHU/DIVU/REMU sequencer that borrows the shared ALU for its
// per-bit add (shift-add multiply) or subtract (restoring divide) step.
module mdu_alu_sequencer
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  mdu_alu_sequencer_if.slave bus,
  output logic              stall,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_gsel,
  input  logic [XLEN-1:0]   alu_f,
  input  logic              alu_c,
  input  logic              alu_bltu,
  output logic [1:0]        fsm_state
);

  logic [1:0]       state;
  mdu_op_t          op;
  logic [CNT_W-1:0] cnt;
  // hi/lo double as rem/quo for divides; opb is the multiplicand or the divisor
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  opb;

  logic             is_div;
  logic             accept;
  logic             div_zero;
  logic [XLEN-1:0]  part;
  logic             take;

  assign is_div   = op[1];
  assign part     = {hi[XLEN-2:0], lo[XLEN-1]};
  // A set top bit means the partial remainder exceeds any 32-bit divisor
  assign take     = hi[XLEN-1] | ~alu_bltu;
  assign div_zero = bus.req_op[1] && (bus.req_b == '0);

  assign bus.req_ready  = rst_n && (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign stall          = (state != IDLE);
  assign accept         = bus.req_valid && bus.req_ready && !flush;
  assign fsm_state      = state;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_gsel = ALU_ADD;
    if (state == CALC) begin
      if (is_div) begin
        alu_a    = part;
        alu_b    = opb;
        alu_gsel = ALU_SUB;
      end else begin
        alu_a    = hi;
        alu_b    = lo[0] ? opb : '0;
        alu_gsel = ALU_ADD;
      end
    end
  end

  always_comb begin
    bus.resp_data = '0;
    if (state == DONE) begin
      case (op)
        MDU_MUL:   bus.resp_data = lo;
        MDU_MULHU: bus.resp_data = hi;
        MDU_DIVU:  bus.resp_data = lo;
        default:   bus.resp_data = hi;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op    <= MDU_MUL;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opb   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op  <= bus.req_op;
            cnt <= '0;
            if (div_zero) begin
              // Preload the architectural divide-by-zero results into quo/rem
              hi    <= bus.req_a;
              lo    <= '1;
              opb   <= '0;
              state <= DONE;
            end else if (bus.req_op[1]) begin
              hi    <= '0;
              lo    <= bus.req_a;
              opb   <= bus.req_b;
              state <= CALC;
            end else begin
              hi    <= '0;
              lo    <= bus.req_b;
              opb   <= bus.req_a;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (is_div) begin
            hi <= take ? alu_f : part;
            lo <= {lo[XLEN-2:0], take};
          end else begin
            {hi, lo} <= {alu_c, alu_f, lo[XLEN-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) state <= DONE;
        end
        DONE: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
